reg_dump_reader: RTL and testbench

- Debug-side reader for the pipeline register bank: walks registers 0..NUM_REGS-1 over the bank's debug read port and streams each 32-bit value as bytes to the debug UART transmitter.
- Sits between the debug unit command FSM (start/done) and the UART TX byte interface.
- Drives the bank's debug read enable/address; is the read-out counterpart of the WB write path.

---
 rtl/reg_dump_reader_pkg.sv | 24 ++
 rtl/reg_dump_reader_word_serializer.sv | 49 ++++
 rtl/reg_dump_reader.sv | 139 +++++++++++++
 tb/tb_reg_dump_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared types and constants for the register-bank dump reader.
// Holds FSM state encodings, the stream header marker and the byte-per-register helper.
package reg_dump_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4,
    ST_HDR  = 3'd5
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam int DATA_SIZE_DEF = 32;
  localparam int BYTE_SIZE_DEF = 8;
  localparam int BYTES_PER_REG = DATA_SIZE_DEF / BYTE_SIZE_DEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_dump_reader_word_serializer.sv
// Purpose: holds one register word and emits it MSB-first as bytes over valid/ready.
// Latency: first byte is presented the cycle after load; one byte per accepted handshake.
// Backpressure: byte and index hold while tx_ready is low; last_acc pulses on the final handshake.
module reg_dump_reader_word_serializer
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_data,
  input  logic                 en,
  input  logic                 tx_ready,
  output logic [BYTE_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 last_acc
);

  localparam int BPR   = DATA_SIZE / BYTE_SIZE;
  localparam int IDX_W = idx_width(BPR);

  logic [DATA_SIZE-1:0] word;
  logic [DATA_SIZE-1:0] shifted;
  logic [IDX_W-1:0]     idx;
  logic                 at_last;

  assign at_last  = (idx == IDX_W'(BPR - 1));
  assign last_acc = en && tx_ready && at_last;
  assign tx_valid = en;

  // Shift the current byte up to the top so the slice position is constant.
  assign shifted  = word << (BYTE_SIZE * idx);
  assign tx_data  = en ? shifted[DATA_SIZE-1 -: BYTE_SIZE] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= load_data;
      idx  <= '0;
    end else if (en && tx_ready) begin
      idx  <= at_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Purpose: walks bank registers 0..NUM_REGS-1 over the debug read port and streams them as bytes (REG_DUMP_HEADER_EN adds an A5/count header).
// Latency: start edge k -> read strobe in cycle k+1 -> first byte in cycle k+3 (k+1 with header).
// Backpressure: every byte waits for i_tx_ready; the walk stalls in SEND, nothing is dropped.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int NUM_REGS  = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_rb_data,
  output logic                 o_rb_read_enable,
  output logic [REG_SIZE-1:0]  o_rb_read_addr,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [REG_SIZE-1:0] LAST_REG = REG_SIZE'(NUM_REGS - 1);

  state_t                state, state_nxt;
  logic [REG_SIZE-1:0]   counter, counter_nxt;
  logic                  ser_load, ser_en, ser_last, ser_valid;
  logic [BYTE_SIZE-1:0]  ser_data;

`ifdef REG_DUMP_HEADER_EN
  localparam state_t               START_STATE = ST_HDR;
  localparam logic [BYTE_SIZE-1:0] HDR_B0      = BYTE_SIZE'(HDR_MAGIC);
  localparam logic [BYTE_SIZE-1:0] HDR_B1      = BYTE_SIZE'(NUM_REGS % 256);

  logic hdr_idx, hdr_idx_nxt;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) hdr_idx <= 1'b0;
    else          hdr_idx <= hdr_idx_nxt;
  end
`else
  localparam state_t START_STATE = ST_REQ;
`endif

  reg_dump_reader_word_serializer #(
    .DATA_SIZE (DATA_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) u_ser (
    .clk       (i_clock),
    .rst_n     (i_reset),
    .load      (ser_load),
    .load_data (i_rb_data),
    .en        (ser_en),
    .tx_ready  (i_tx_ready),
    .tx_data   (ser_data),
    .tx_valid  (ser_valid),
    .last_acc  (ser_last)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    counter_nxt      = counter;
    ser_load         = 1'b0;
    ser_en           = 1'b0;
    o_rb_read_enable = 1'b0;
    o_rb_read_addr   = '0;
    o_tx_valid       = 1'b0;
    o_tx_data        = '0;
    o_busy           = 1'b0;
    o_done           = 1'b0;
`ifdef REG_DUMP_HEADER_EN
    hdr_idx_nxt      = hdr_idx;
`endif
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          counter_nxt = '0;
          state_nxt   = START_STATE;
        end
      end
`ifdef REG_DUMP_HEADER_EN
      ST_HDR: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = hdr_idx ? HDR_B1 : HDR_B0;
        if (i_tx_ready) begin
          hdr_idx_nxt = ~hdr_idx;
          if (hdr_idx) state_nxt = ST_REQ;
        end
      end
`endif
      ST_REQ: begin
        o_busy           = 1'b1;
        o_rb_read_enable = 1'b1;
        o_rb_read_addr   = counter;
        state_nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        // Bank data is only valid this cycle; the serializer captures it at the edge.
        o_busy    = 1'b1;
        ser_load  = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_busy     = 1'b1;
        ser_en     = 1'b1;
        o_tx_valid = ser_valid;
        o_tx_data  = ser_data;
        if (ser_last) begin
          if (counter == LAST_REG) begin
            state_nxt = ST_DONE;
          end else begin
            counter_nxt = counter + 1'b1;
            state_nxt   = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        counter_nxt = '0;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: bank model, byte monitor and immediate-assertion checks.
module tb_reg_dump_reader;

`ifdef REG_DUMP_HEADER_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic [31:0] i_rb_data = 32'hDEADBEEF;
  logic        o_rb_read_enable;
  logic [4:0]  o_rb_read_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] bytes_q[$];
  int         addr_q[$];
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         stab_err = 0;
  int         b2b_err = 0;
  time        done_time = 0;

  logic       m_pv = 1'b0;
  logic       m_pnr = 1'b0;
  logic       m_pen = 1'b0;
  logic [7:0] m_pd = 8'h00;

  logic       b_en = 1'b0;
  logic [4:0] b_addr = 5'd0;

  bit         rnd_mode = 1'b0;

  reg_dump_reader dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_rb_data        (i_rb_data),
    .o_rb_read_enable (o_rb_read_enable),
    .o_rb_read_addr   (o_rb_read_addr),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_stream(input int j);
    logic [31:0] v;
    if (j < HDR_N) return (j == 0) ? 8'hA5 : 8'h20;
    v = 32'h11223344 + 32'((j - HDR_N) / 4);
    return v[31 - 8 * ((j - HDR_N) % 4) -: 8];
  endfunction

  // Bank model: data appears only the cycle after the read strobe, junk otherwise.
  initial begin
    forever begin
      @(negedge i_clock);
      b_en   = o_rb_read_enable;
      b_addr = o_rb_read_addr;
      @(posedge i_clock);
      #1;
      i_rb_data = b_en ? (32'h11223344 + 32'(b_addr)) : 32'hDEADBEEF;
    end
  end

  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      i_tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor samples mid-cycle; a handshake seen here is taken at the next rising edge.
  initial begin
    forever begin
      @(negedge i_clock);
      if (i_reset && m_pv && m_pnr && !(o_tx_valid && o_tx_data == m_pd)) stab_err++;
      if (o_tx_valid && i_tx_ready) bytes_q.push_back(o_tx_data);
      if (o_rb_read_enable) begin
        rd_cnt++;
        addr_q.push_back(int'(o_rb_read_addr));
        if (m_pen) b2b_err++;
      end
      if (o_done) begin
        done_cnt++;
        done_time = $time;
      end
      m_pv  = o_tx_valid;
      m_pnr = !i_tx_ready;
      m_pd  = o_tx_data;
      m_pen = o_rb_read_enable;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic pulse_start(output time t0);
    @(posedge i_clock);
    #1 i_start = 1'b1;
    @(posedge i_clock);
    t0 = $time;
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int i = 0;
    while (done_cnt == base && i < budget) begin
      @(posedge i_clock);
      i++;
    end
    check("done_seen", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_dump(input string tag, input int bb, input int ab, input int rb);
    int errs = 0;
    int aerr = 0;
    check({tag, "_byte_count"}, 32'(bytes_q.size() - bb), 32'(128 + HDR_N));
    for (int i = 0; i < 128 + HDR_N; i++)
      if (bytes_q[bb + i] !== exp_stream(i)) errs++;
    check({tag, "_stream_errs"}, 32'(errs), 32'd0);
    check({tag, "_rd_count"}, 32'(rd_cnt - rb), 32'd32);
    for (int i = 0; i < 32; i++)
      if (addr_q[ab + i] != i) aerr++;
    check({tag, "_addr_order_errs"}, 32'(aerr), 32'd0);
  endtask

  initial begin
    time t0;
    int  bb, ab, rb, db, cyc, i;

    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_rd_en", 32'(o_rb_read_enable), 32'd0);
    check("rst_rd_addr", 32'(o_rb_read_addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    @(posedge i_clock);
    #1 i_reset = 1'b1;
    repeat (2) @(posedge i_clock);

    // Full dump, ready held high
    bb = bytes_q.size(); ab = addr_q.size(); rb = rd_cnt; db = done_cnt;
    pulse_start(t0);
    @(negedge i_clock);
`ifdef REG_DUMP_HEADER_EN
    check("k1_tx_valid", 32'(o_tx_valid), 32'd1);
    check("k1_tx_data", 32'(o_tx_data), 32'hA5);
    check("k1_busy", 32'(o_busy), 32'd1);
    @(negedge i_clock);
    check("k2_tx_data", 32'(o_tx_data), 32'h20);
    check("k2_rd_en", 32'(o_rb_read_enable), 32'd0);
    @(negedge i_clock);
    check("k3_rd_en", 32'(o_rb_read_enable), 32'd1);
    check("k3_tx_valid", 32'(o_tx_valid), 32'd0);
`else
    check("k1_rd_en", 32'(o_rb_read_enable), 32'd1);
    check("k1_rd_addr", 32'(o_rb_read_addr), 32'd0);
    check("k1_busy", 32'(o_busy), 32'd1);
    check("k1_tx_valid", 32'(o_tx_valid), 32'd0);
    @(negedge i_clock);
    check("k2_rd_en", 32'(o_rb_read_enable), 32'd0);
    check("k2_tx_valid", 32'(o_tx_valid), 32'd0);
    @(negedge i_clock);
    check("k3_tx_valid", 32'(o_tx_valid), 32'd1);
    check("k3_tx_data", 32'(o_tx_data), 32'h11);
`endif
    wait_done(db, 400);
    cyc = int'((done_time - t0 - 5) / 10) + 1;
    check("done_cycle", 32'(cyc), 32'(193 + HDR_N));
    @(negedge i_clock);
    check("busy_after", 32'(o_busy), 32'd0);
    check("done_after", 32'(o_done), 32'd0);
    check_dump("plain", bb, ab, rb);
    check("byte0", 32'(bytes_q[bb + HDR_N]), 32'h11);
    check("byte3", 32'(bytes_q[bb + HDR_N + 3]), 32'h44);
    check("byte7", 32'(bytes_q[bb + HDR_N + 7]), 32'h45);
    check("byte127", 32'(bytes_q[bb + HDR_N + 127]), 32'h63);
    check("rd_b2b_errs", 32'(b2b_err), 32'd0);
    check("done_count_plain", 32'(done_cnt - db), 32'd1);

    // Random backpressure plus ignored start pulses at bytes 5 and 100
    rnd_mode = 1'b1;
    bb = bytes_q.size(); ab = addr_q.size(); rb = rd_cnt; db = done_cnt;
    pulse_start(t0);
    i = 0;
    while (bytes_q.size() - bb < 5 && i < 200) begin @(posedge i_clock); i++; end
    #1 i_start = 1'b1;
    @(posedge i_clock);
    #1 i_start = 1'b0;
    i = 0;
    while (bytes_q.size() - bb < 100 && i < 1500) begin @(posedge i_clock); i++; end
    #1 i_start = 1'b1;
    @(posedge i_clock);
    #1 i_start = 1'b0;
    wait_done(db, 1500);
    repeat (12) @(posedge i_clock);
    check("done_count_rand", 32'(done_cnt - db), 32'd1);
    check_dump("rand", bb, ab, rb);
    check("stable_errs", 32'(stab_err), 32'd0);
    check("rd_b2b_errs_rand", 32'(b2b_err), 32'd0);
    rnd_mode = 1'b0;
    repeat (2) @(posedge i_clock);

    // Reset during SEND of register 7 byte 2
    bb = bytes_q.size(); db = done_cnt;
    pulse_start(t0);
    i = 0;
    while (bytes_q.size() < bb + HDR_N + 30 && i < 400) begin @(posedge i_clock); i++; end
    #2;
    check("pre_rst_tx_valid", 32'(o_tx_valid), 32'd1);
    check("pre_rst_tx_data", 32'(o_tx_data), 32'h33);
    i_reset = 1'b0;
    #1;
    check("arst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("arst_tx_data", 32'(o_tx_data), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_rd_en", 32'(o_rb_read_enable), 32'd0);
    check("arst_done", 32'(o_done), 32'd0);
    repeat (5) @(posedge i_clock);
    check("arst_no_done", 32'(done_cnt - db), 32'd0);
    check("arst_byte_count", 32'(bytes_q.size() - bb), 32'(HDR_N + 30));
    #1 i_reset = 1'b1;
    repeat (2) @(posedge i_clock);

    bb = bytes_q.size(); ab = addr_q.size(); rb = rd_cnt; db = done_cnt;
    pulse_start(t0);
    wait_done(db, 400);
    cyc = int'((done_time - t0 - 5) / 10) + 1;
    check("restart_done_cycle", 32'(cyc), 32'(193 + HDR_N));
    check_dump("restart", bb, ab, rb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
